// File: rtl/md_pkg.sv
// Shared encodings and defaults for the multiply/divide unit.
package md_pkg;

   typedef enum logic [2:0] {
      MD_NONE  = 3'd0,
      MD_MULT  = 3'd1,
      MD_MULTU = 3'd2,
      MD_DIV   = 3'd3,
      MD_DIVU  = 3'd4,
      MD_MTHI  = 3'd5,
      MD_MTLO  = 3'd6,
      MD_RSVD  = 3'd7
   } md_op_e;

   typedef enum logic {
      MD_IDLE = 1'b0,
      MD_RUN  = 1'b1
   } md_state_e;

   localparam int MD_MULT_CYCLES_DEF = 5;
   localparam int MD_DIV_CYCLES_DEF  = 10;

   // True for the ops that occupy the unit for a multi-cycle busy period.
   function automatic logic md_is_arith(input md_op_e op);
      return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
   endfunction

endpackage

// File: rtl/md_calc.sv
// Combinational multiply/divide datapath: {hi,lo} result for one operation.
module md_calc
   import md_pkg::*;
(
   input  md_op_e      op,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic [63:0] result,
   output logic        div_by_zero
);

   // Signed divide done at 33 bits so 0x80000000 / -1 yields +2^31, whose low
   // word is 0x80000000 with remainder 0. Returns {remainder, quotient}.
   function automatic logic [63:0] sdivmod(input logic [31:0] n, input logic [31:0] d);
      logic signed [32:0] n_s;
      logic signed [32:0] d_s;
      logic signed [32:0] q_s;
      logic signed [32:0] r_s;
      n_s = {n[31], n};
      d_s = (d == 32'd0) ? 33'sd1 : {d[31], d};
      q_s = n_s / d_s;
      r_s = n_s % d_s;
      return {r_s[31:0], q_s[31:0]};
   endfunction

   // Unsigned divide; a zero divisor is replaced so the result is defined.
   function automatic logic [63:0] udivmod(input logic [31:0] n, input logic [31:0] d);
      logic [31:0] d_u;
      d_u = (d == 32'd0) ? 32'd1 : d;
      return {n % d_u, n / d_u};
   endfunction

   logic signed [63:0] a_s;
   logic signed [63:0] b_s;
   logic signed [63:0] sprod;
   logic        [63:0] uprod;

   assign a_s   = {{32{a[31]}}, a};
   assign b_s   = {{32{b[31]}}, b};
   assign sprod = a_s * b_s;
   assign uprod = {32'd0, a} * {32'd0, b};

   // Select the result for the requested op; divisor-zero flagged for divides only.
   always_comb begin
      result      = 64'd0;
      div_by_zero = 1'b0;
      case (op)
         MD_MULT:  result = sprod;
         MD_MULTU: result = uprod;
         MD_DIV: begin
            result      = sdivmod(a, b);
            div_by_zero = (b == 32'd0);
         end
         MD_DIVU: begin
            result      = udivmod(a, b);
            div_by_zero = (b == 32'd0);
         end
         default:  result = 64'd0;
      endcase
   end

endmodule

// File: rtl/md_unit.sv
// HI/LO owner for the EX stage: runs mult/div for a fixed busy period,
// commits the shadowed result at the end, and handles mthi/mtlo directly.
module md_unit
   import md_pkg::*;
#(
   parameter int MULT_CYCLES = MD_MULT_CYCLES_DEF,
   parameter int DIV_CYCLES  = MD_DIV_CYCLES_DEF
)(
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [2:0]  md_op,
   input  logic        cancel,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic        busy,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   localparam logic [3:0] MULT_CNT = 4'(MULT_CYCLES);
   localparam logic [3:0] DIV_CNT  = 4'(DIV_CYCLES);

   md_op_e      op_e;
   md_state_e   state;
   logic [3:0]  cnt;
   logic [31:0] pend_hi;
   logic [31:0] pend_lo;
   logic        pend_ok;
   logic        accept;
   logic [63:0] calc_res;
   logic        calc_dz;

   assign op_e   = md_op_e'(md_op);
   assign accept = start & ~cancel & ~busy & (op_e != MD_NONE) & (op_e != MD_RSVD);

   md_calc u_calc (
      .op          (op_e),
      .a           (a),
      .b           (b),
      .result      (calc_res),
      .div_by_zero (calc_dz)
   );

   // Control FSM, down-counter, shadow result and HI/LO registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= MD_IDLE;
         cnt     <= 4'd0;
         busy    <= 1'b0;
         pend_hi <= 32'd0;
         pend_lo <= 32'd0;
         pend_ok <= 1'b0;
         hi      <= 32'd0;
         lo      <= 32'd0;
      end else begin
         case (state)
            MD_IDLE: begin
               if (accept) begin
                  if (md_is_arith(op_e)) begin
                     // result is fixed at acceptance; the busy period only models latency
                     pend_hi <= calc_res[63:32];
                     pend_lo <= calc_res[31:0];
                     pend_ok <= ~calc_dz;
                     cnt     <= ((op_e == MD_MULT) || (op_e == MD_MULTU)) ? MULT_CNT : DIV_CNT;
                     busy    <= 1'b1;
                     state   <= MD_RUN;
                  end else if (op_e == MD_MTHI) begin
                     hi <= a;
                  end else if (op_e == MD_MTLO) begin
                     lo <= a;
                  end
               end
            end
            MD_RUN: begin
               cnt <= cnt - 4'd1;
               if (cnt == 4'd1) begin
                  // divide-by-zero runs the full period but leaves HI/LO untouched
                  if (pend_ok) begin
                     hi <= pend_hi;
                     lo <= pend_lo;
                  end
                  busy  <= 1'b0;
                  state <= MD_IDLE;
               end
            end
            default: begin
               state <= MD_IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit: directed table, hand sequences, random ops.
module tb_md_unit;

   localparam int MC = 5;
   localparam int DC = 10;

   logic        clk;
   logic        reset;
   logic        start;
   logic [2:0]  md_op;
   logic        cancel;
   logic [31:0] a;
   logic [31:0] b;
   logic        busy;
   logic [31:0] hi;
   logic [31:0] lo;

   int checks   = 0;
   int failures = 0;

   logic [31:0] m_hi;
   logic [31:0] m_lo;

   md_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
      .clk    (clk),
      .reset  (reset),
      .start  (start),
      .md_op  (md_op),
      .cancel (cancel),
      .a      (a),
      .b      (b),
      .busy   (busy),
      .hi     (hi),
      .lo     (lo)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [2:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] hi;
      logic [31:0] lo;
      int          nb;
   } vec_t;

   vec_t tbl[13];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Issue one op, then count busy cycles until it drops (bounded).
   // inj: 0 nothing, 1 pulse cancel in busy cycle 3, 2 try a mult in busy cycle 3.
   task automatic run_op(input logic [2:0] op, input logic [31:0] av, input logic [31:0] bv,
                         input logic cx, input int inj, output int nb);
      start  = 1'b1;
      md_op  = op;
      a      = av;
      b      = bv;
      cancel = cx;
      tick();
      start  = 1'b0;
      cancel = 1'b0;
      nb     = 0;
      while (busy === 1'b1 && nb < 40) begin
         start  = 1'b0;
         cancel = 1'b0;
         if (nb == 2 && inj == 1) cancel = 1'b1;
         if (nb == 2 && inj == 2) begin
            start = 1'b1;
            md_op = 3'd1;
            a     = 32'd3;
            b     = 32'd3;
         end
         nb++;
         tick();
      end
      start  = 1'b0;
      cancel = 1'b0;
   endtask

   // Architectural reference: what HI/LO become after an accepted op.
   function automatic void ref_apply(input logic [2:0] op, input logic [31:0] av, input logic [31:0] bv);
      longint      sa;
      longint      sb;
      longint      sp;
      longint      q;
      longint      r;
      logic [63:0] up;
      sa = longint'($signed(av));
      sb = longint'($signed(bv));
      case (op)
         3'd1: begin sp = sa * sb; m_hi = sp[63:32]; m_lo = sp[31:0]; end
         3'd2: begin up = {32'd0, av} * {32'd0, bv}; m_hi = up[63:32]; m_lo = up[31:0]; end
         3'd3: if (bv != 0) begin q = sa / sb; r = sa % sb; m_lo = q[31:0]; m_hi = r[31:0]; end
         3'd4: if (bv != 0) begin m_lo = av / bv; m_hi = av % bv; end
         3'd5: m_hi = av;
         3'd6: m_lo = av;
         default: ;
      endcase
   endfunction

   function automatic int ncyc(input logic [2:0] op);
      if (op == 3'd1 || op == 3'd2) return MC;
      if (op == 3'd3 || op == 3'd4) return DC;
      return 0;
   endfunction

   function automatic logic [31:0] pick32();
      case ($urandom_range(0, 7))
         0: return 32'd0;
         1: return 32'h8000_0000;
         2: return 32'hFFFF_FFFF;
         3: return 32'd1;
         default: return $urandom;
      endcase
   endfunction

   initial begin
      int nb;
      int en;
      logic [2:0]  rop;
      logic [31:0] ra;
      logic [31:0] rb;
      logic        rc;

      tbl[0]  = '{3'd1, 32'hFFFF_FFFF, 32'd2,          32'hFFFF_FFFF, 32'hFFFF_FFFE, MC};
      tbl[1]  = '{3'd2, 32'hFFFF_FFFF, 32'd2,          32'h0000_0001, 32'hFFFF_FFFE, MC};
      tbl[2]  = '{3'd3, 32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFF, 32'hFFFF_FFFD, DC};
      tbl[3]  = '{3'd4, 32'd7,         32'd2,          32'd1,         32'd3,         DC};
      tbl[4]  = '{3'd3, 32'h8000_0000, 32'hFFFF_FFFF,  32'd0,         32'h8000_0000, DC};
      tbl[5]  = '{3'd5, 32'hAA,        32'd0,          32'hAA,        32'h8000_0000, 0};
      tbl[6]  = '{3'd6, 32'hBB,        32'd0,          32'hAA,        32'hBB,        0};
      tbl[7]  = '{3'd4, 32'd5,         32'd0,          32'hAA,        32'hBB,        DC};
      tbl[8]  = '{3'd3, 32'd5,         32'd0,          32'hAA,        32'hBB,        DC};
      tbl[9]  = '{3'd1, 32'h8000_0000, 32'h8000_0000,  32'h4000_0000, 32'd0,         MC};
      tbl[10] = '{3'd3, 32'd7,         32'hFFFF_FFFE,  32'd1,         32'hFFFF_FFFD, DC};
      tbl[11] = '{3'd0, 32'h55,        32'h66,         32'd1,         32'hFFFF_FFFD, 0};
      tbl[12] = '{3'd7, 32'h55,        32'h66,         32'd1,         32'hFFFF_FFFD, 0};

      reset  = 1'b1;
      start  = 1'b0;
      md_op  = 3'd0;
      cancel = 1'b0;
      a      = 32'd0;
      b      = 32'd0;
      tick();
      tick();
      chk("reset_busy", {63'd0, busy}, 64'd0);
      chk("reset_hi", {32'd0, hi}, 64'd0);
      chk("reset_lo", {32'd0, lo}, 64'd0);
      reset = 1'b0;
      tick();

      // Directed table, issued back-to-back
      for (int i = 0; i < 13; i++) begin
         run_op(tbl[i].op, tbl[i].a, tbl[i].b, 1'b0, 0, nb);
         chk($sformatf("tbl%0d_busy", i), 64'(nb), 64'(tbl[i].nb));
         chk($sformatf("tbl%0d_hi", i), {32'd0, hi}, {32'd0, tbl[i].hi});
         chk($sformatf("tbl%0d_lo", i), {32'd0, lo}, {32'd0, tbl[i].lo});
      end

      // mthi then mtlo on consecutive cycles
      start = 1'b1; md_op = 3'd5; a = 32'h1234;
      tick();
      chk("mthi_hi", {32'd0, hi}, 64'h1234);
      chk("mthi_busy", {63'd0, busy}, 64'd0);
      md_op = 3'd6; a = 32'h5678;
      tick();
      start = 1'b0;
      chk("mtlo_lo", {32'd0, lo}, 64'h5678);
      chk("mtlo_hi", {32'd0, hi}, 64'h1234);
      chk("mtlo_busy", {63'd0, busy}, 64'd0);

      // mult attempted while a div is busy: ignored
      run_op(3'd3, 32'd100, 32'd7, 1'b0, 2, nb);
      chk("ovl_busy", 64'(nb), 64'(DC));
      chk("ovl_hi", {32'd0, hi}, 64'd2);
      chk("ovl_lo", {32'd0, lo}, 64'd14);
      repeat (MC + 3) tick();
      chk("ovl_late_busy", {63'd0, busy}, 64'd0);
      chk("ovl_late_lo", {32'd0, lo}, 64'd14);

      // cancel while busy has no effect
      run_op(3'd1, 32'd6, 32'd7, 1'b0, 1, nb);
      chk("cxbusy_busy", 64'(nb), 64'(MC));
      chk("cxbusy_lo", {32'd0, lo}, 64'd42);
      chk("cxbusy_hi", {32'd0, hi}, 64'd0);

      // start together with cancel is dropped
      run_op(3'd5, 32'h77, 32'd0, 1'b0, 0, nb);
      run_op(3'd3, 32'd100, 32'd7, 1'b1, 0, nb);
      chk("cxstart_busy", 64'(nb), 64'd0);
      run_op(3'd6, 32'h99, 32'd0, 1'b1, 0, nb);
      repeat (DC + 2) tick();
      chk("cxstart_hi", {32'd0, hi}, 64'h77);
      chk("cxstart_lo", {32'd0, lo}, 64'd42);
      chk("cxstart_busy2", {63'd0, busy}, 64'd0);

      // reset in the 3rd busy cycle of a div
      start = 1'b1; md_op = 3'd3; a = 32'd100; b = 32'd7;
      tick();
      start = 1'b0;
      chk("rmid_busy1", {63'd0, busy}, 64'd1);
      tick();
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("rmid_busy", {63'd0, busy}, 64'd0);
      chk("rmid_hi", {32'd0, hi}, 64'd0);
      chk("rmid_lo", {32'd0, lo}, 64'd0);
      repeat (DC + 2) tick();
      chk("rmid_late_hi", {32'd0, hi}, 64'd0);
      chk("rmid_late_lo", {32'd0, lo}, 64'd0);
      chk("rmid_late_busy", {63'd0, busy}, 64'd0);

      // Randomized ops against the reference model
      m_hi = 32'd0;
      m_lo = 32'd0;
      for (int i = 0; i < 200; i++) begin
         rop = 3'($urandom_range(0, 7));
         ra  = pick32();
         rb  = pick32();
         rc  = ($urandom_range(0, 7) == 0);
         en  = 0;
         if (!rc && rop != 3'd0 && rop != 3'd7) begin
            en = ncyc(rop);
            ref_apply(rop, ra, rb);
         end
         run_op(rop, ra, rb, rc, 0, nb);
         chk($sformatf("rnd%0d_op%0d_busy", i, rop), 64'(nb), 64'(en));
         chk($sformatf("rnd%0d_op%0d_hi", i, rop), {32'd0, hi}, {32'd0, m_hi});
         chk($sformatf("rnd%0d_op%0d_lo", i, rop), {32'd0, lo}, {32'd0, m_lo});
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
